incr_case_matcher: RTL and testbench

Registered, parametrised case-item matcher with post-incrementing match keys. Each accepted input selector is compared against an ordered table of NKEYS keys. The first match wins and produces a code, as in a priority case statement. Keys flagged in INC_MASK post-increment: the comparison uses the old value and the key is bumped afterwards, under a selectable evaluation policy. The block serves as a defined-semantics reference for case items with side effects, with valid/ready streaming on both sides.

---
 rtl/incr_case_matcher.sv | 133 +++++++++++++
 tb/tb_incr_case_matcher.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/incr_case_matcher.sv
// ---------------------------------------------------------------------------
// incr_case_matcher
//
// Registered priority matcher over a table of NKEYS keys, with optional
// post-increment keys. An accepted selector is compared against the keys in
// ascending index order. The lowest matching index wins. The result is
// registered one cycle later. Keys flagged in INC_MASK are incremented at
// the same edge, using the value they had before the comparison.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   load_valid - write key[load_idx] = load_val this cycle
//   load_idx   - key index to write (indices >= NKEYS are ignored)
//   load_val   - key value to write
//   in_valid   - selector valid
//   in_ready   - block can accept a selector (!out_valid || out_ready)
//   in_sel     - selector to match
//   out_valid  - result valid
//   out_ready  - downstream accepts the result
//   out_code   - i+1 for a match at index i, 0 for no match
//   out_hit    - any key matched
//   out_idx    - matched index (0 for no match)
// ---------------------------------------------------------------------------
module incr_case_matcher #(
    parameter int unsigned       WIDTH    = 4,
    parameter int unsigned       NKEYS    = 2,
    parameter int unsigned       OUTW     = 32,
    parameter logic [NKEYS-1:0]  INC_MASK = NKEYS'(1),
    parameter int unsigned       INC_MODE = 0,
    parameter logic [WIDTH-1:0]  KEY_RST  = '0,
    localparam int unsigned      IW       = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [IW-1:0]    load_idx,
    input  logic [WIDTH-1:0] load_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUTW-1:0]  out_code,
    output logic             out_hit,
    output logic [IW-1:0]    out_idx
);

    logic [WIDTH-1:0] key_q [NKEYS];
    logic [WIDTH-1:0] key_d [NKEYS];

    logic             out_valid_q, out_valid_d;
    logic [OUTW-1:0]  out_code_q,  out_code_d;
    logic             out_hit_q,   out_hit_d;
    logic [IW-1:0]    out_idx_q,   out_idx_d;

    logic             xfer;
    logic             found;
    logic [IW-1:0]    match_idx;
    logic [OUTW-1:0]  match_code;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    // Single ascending scan: a key counts as "evaluated" while no lower
    // index has matched yet. This gives both the priority match and the
    // set of keys that INC_MODE=1 bumps.
    always_comb begin
        found      = 1'b0;
        match_idx  = '0;
        match_code = '0;
        key_d      = key_q;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (xfer && INC_MASK[i] &&
                ((INC_MODE == 1) ? !found : (!found && key_q[i] == in_sel))) begin
                key_d[i] = key_q[i] + WIDTH'(1);
            end
            if (!found && key_q[i] == in_sel) begin
                found      = 1'b1;
                match_idx  = IW'(i);
                match_code = OUTW'(i + 1);
            end
        end
        // A load is applied after the increment, so it wins on a collision.
        // An out-of-range index matches no entry and is dropped.
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (load_valid && load_idx == IW'(i)) begin
                key_d[i] = load_val;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_code_d  = match_code;
            out_hit_d   = found;
            out_idx_d   = match_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                key_q[i] <= KEY_RST;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_incr_case_matcher.sv
module tb_incr_case_matcher;

    localparam logic [1:0] MASK = 2'b01;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_idx   = 1'b0;
    logic [3:0]  load_val   = '0;
    logic        in_valid   = 1'b0;
    logic [3:0]  in_sel     = '0;
    logic        out_ready  = 1'b1;

    // Instance 0: INC_MODE=0, instance 1: INC_MODE=1, same stimulus.
    logic        in_ready0, out_valid0, out_hit0, out_idx0;
    logic [31:0] out_code0;
    logic        in_ready1, out_valid1, out_hit1, out_idx1;
    logic [31:0] out_code1;

    incr_case_matcher #(.WIDTH(4), .NKEYS(2), .OUTW(32), .INC_MASK(MASK),
                        .INC_MODE(0), .KEY_RST(4'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_idx(load_idx),
        .load_val(load_val), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sel(in_sel), .out_valid(out_valid0), .out_ready(out_ready),
        .out_code(out_code0), .out_hit(out_hit0), .out_idx(out_idx0));

    incr_case_matcher #(.WIDTH(4), .NKEYS(2), .OUTW(32), .INC_MASK(MASK),
                        .INC_MODE(1), .KEY_RST(4'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_idx(load_idx),
        .load_val(load_val), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sel(in_sel), .out_valid(out_valid1), .out_ready(out_ready),
        .out_code(out_code1), .out_hit(out_hit1), .out_idx(out_idx1));

    // Reference model: key tables and expected outputs per mode.
    int          mk [2][2];
    logic        e_valid = 1'b0;
    logic        e_hit  [2];
    logic        e_idx  [2];
    logic [31:0] e_code [2];

    int nvec = 0;
    int nerr = 0;

    function automatic logic [71:0] obs();
        return {in_ready0, out_valid0, out_hit0, out_idx0, out_code0,
                in_ready1, out_valid1, out_hit1, out_idx1, out_code1};
    endfunction

    function automatic logic [71:0] expv();
        logic rdy;
        rdy = !e_valid || out_ready;
        return {rdy, e_valid, e_hit[0], e_idx[0], e_code[0],
                rdy, e_valid, e_hit[1], e_idx[1], e_code[1]};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit xfer;
        xfer = in_valid && (!e_valid || out_ready);
        if (!rst_n) begin
            e_valid = 1'b0;
            for (int md = 0; md < 2; md++) begin
                e_hit[md] = 1'b0; e_idx[md] = 1'b0; e_code[md] = 0;
                mk[md][0] = 0; mk[md][1] = 0;
            end
        end else begin
            if (xfer) begin
                e_valid = 1'b1;
                for (int md = 0; md < 2; md++) begin
                    int m;
                    m = -1;
                    for (int i = 0; i < 2; i++)
                        if (m < 0 && mk[md][i] == int'(in_sel)) m = i;
                    e_hit[md]  = (m >= 0);
                    e_idx[md]  = (m >= 0) ? m[0] : 1'b0;
                    e_code[md] = (m >= 0) ? 32'(m + 1) : 32'd0;
                    for (int i = 0; i < 2; i++) begin
                        if (MASK[i] && ((md == 0) ? (i == m) : (m < 0 || i <= m)))
                            mk[md][i] = (mk[md][i] + 1) % 16;
                    end
                end
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            if (load_valid) begin
                mk[0][load_idx] = int'(load_val);
                mk[1][load_idx] = int'(load_val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic idx, input logic [3:0] val);
        load_valid = 1'b1; load_idx = idx; load_val = val;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] sel);
        in_valid = 1'b1; in_sel = sel;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvec++;
        if (obs() !== expv()) begin
            nerr++; $display("FAIL reset: got %h want %h", obs(), expv());
        end
        nvec++;
        if ({out_valid0, out_hit0, out_idx0, out_code0, out_valid1} !== 36'd0) begin
            nerr++; $display("FAIL reset_zero: got %h want 0",
                             {out_valid0, out_hit0, out_idx0, out_code0, out_valid1});
        end
    endtask

    task automatic test_post_increment();
        do_load(1'b0, 4'd5);
        do_load(1'b1, 4'd0);
        send(4'd5);
        nvec++;
        if (obs() !== expv()) begin
            nerr++; $display("FAIL postinc_first: got %h want %h", obs(), expv());
        end
        nvec++;
        if ({out_hit0, out_idx0, out_code0} !== {1'b1, 1'b0, 32'd1}) begin
            nerr++; $display("FAIL postinc_first_code: got %h want 1", out_code0);
        end
        send(4'd5);
        nvec++;
        if (obs() !== expv()) begin
            nerr++; $display("FAIL postinc_second: got %h want %h", obs(), expv());
        end
        nvec++;
        if ({out_hit0, out_code0} !== {1'b0, 32'd0}) begin
            nerr++; $display("FAIL postinc_second_code: got %h want 0", out_code0);
        end
        tick();
    endtask

    task automatic test_priority_wrap();
        logic [3:0] seq [3];
        seq = '{4'd15, 4'd0, 4'd0};
        do_load(1'b0, 4'd15);
        do_load(1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            send(seq[k]);
            nvec++;
            if (obs() !== expv()) begin
                nerr++; $display("FAIL prio_wrap[%0d]: got %h want %h", k, obs(), expv());
            end
        end
        nvec++;
        if ({out_idx0, out_code0} !== {1'b1, 32'd2}) begin
            nerr++; $display("FAIL prio_wrap_idx1: got %0d want 2", out_code0);
        end
        tick();
    endtask

    task automatic test_inc_mode();
        logic [3:0] seq [3];
        seq = '{4'd3, 4'd0, 4'd5};
        do_load(1'b0, 4'd5);
        do_load(1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            send(seq[k]);
            nvec++;
            if (obs() !== expv()) begin
                nerr++; $display("FAIL inc_mode[%0d]: got %h want %h", k, obs(), expv());
            end
        end
        // Mode 0 kept key0=5, mode 1 moved it to 7.
        nvec++;
        if ({out_code0, out_code1} !== {32'd1, 32'd0}) begin
            nerr++; $display("FAIL inc_mode_diverge: got %0d/%0d want 1/0", out_code0, out_code1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        do_load(1'b0, 4'd5);
        do_load(1'b1, 4'd7);
        send(4'd5);
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 4'd7;
        #1;
        nvec++;
        if (obs() !== expv()) begin
            nerr++; $display("FAIL bp_stall: got %h want %h", obs(), expv());
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++;
            if (obs() !== expv()) begin
                nerr++; $display("FAIL bp_hold[%0d]: got %h want %h", k, obs(), expv());
            end
        end
        out_ready = 1'b1;
        #1;
        nvec++;
        if ({in_ready0, in_ready1} !== 2'b11) begin
            nerr++; $display("FAIL bp_release_ready: got %b want 11", {in_ready0, in_ready1});
        end
        tick();
        in_valid = 1'b0;
        nvec++;
        if (obs() !== expv()) begin
            nerr++; $display("FAIL bp_release: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_load_collision();
        do_load(1'b0, 4'd5);
        load_valid = 1'b1; load_idx = 1'b0; load_val = 4'd9;
        send(4'd5);
        load_valid = 1'b0;
        nvec++;
        if (obs() !== expv() || out_code0 !== 32'd1) begin
            nerr++; $display("FAIL collision: got %h want %h", obs(), expv());
        end
        send(4'd9);
        nvec++;
        if (obs() !== expv() || out_code0 !== 32'd1) begin
            nerr++; $display("FAIL collision_after: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_load(1'b0, 4'd3);
        do_load(1'b1, 4'd12);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel = 4'(3 + k);
            tick();
            nvec++;
            if (obs() !== expv() || out_code0 !== 32'd1) begin
                nerr++; $display("FAIL b2b[%0d]: got %h want %h", k, obs(), expv());
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        do_load(1'b0, 4'd2);
        out_ready = 1'b0;
        send(4'd2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvec++;
        if (obs() !== expv() || out_valid0 !== 1'b0) begin
            nerr++; $display("FAIL mid_reset: got %h want %h", obs(), expv());
        end
        out_ready = 1'b1;
        send(4'd0);
        nvec++;
        if (obs() !== expv() || out_code0 !== 32'd1 || out_code1 !== 32'd1) begin
            nerr++; $display("FAIL mid_reset_after: got %h want %h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = $urandom_range(0, 1) == 1;
            load_valid = ($urandom_range(0, 5) == 0);
            load_idx   = 1'($urandom_range(0, 1));
            load_val   = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       in_sel = 4'(mk[0][0]);
                1:       in_sel = 4'(mk[1][1]);
                default: in_sel = 4'($urandom_range(0, 15));
            endcase
            tick();
            nvec++;
            if (obs() !== expv()) begin
                nerr++; $display("FAIL random[%0d]: got %h want %h", k, obs(), expv());
            end
        end
        rst_n = 1'b1; in_valid = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_post_increment();
        test_priority_wrap();
        test_inc_mode();
        test_backpressure();
        test_load_collision();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
